// File: rtl/neuron_act_requant.sv
// neuron_act_requant
//   Output stage of a 4-input neuron. The signed weighted sum gets a constant bias, is rescaled
//   by an arithmetic right shift with round-half-up, optionally passed through ReLU, and is
//   saturated to the next layer's input width. Two registered stages with valid/ready on both
//   sides. The pipe holds at most two results and stalls without loss.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   in_valid   in_sum valid this cycle
//   in_ready   stage can accept in_sum this cycle (combinational from out_ready)
//   in_sum     signed IN_W-bit weighted sum
//   out_valid  out_act valid this cycle
//   out_ready  consumer accepts out_act this cycle
//   out_act    signed OUT_W-bit activation (registered)
//   out_sat    out_act was clipped (registered, travels with out_act)
//   sat_clr    synchronous clear of sat_count, wins over a same-cycle increment
//   sat_count  saturated results delivered, sticks at all-ones
module neuron_act_requant #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8,
  parameter int          BIAS  = 0,
  parameter bit          RELU  = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_act,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam int unsigned TW  = IN_W + 1;  // biased sum, cannot overflow
  localparam int unsigned RW  = IN_W + 2;  // rounded sum, cannot overflow
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [TW-1:0] BiasT = TW'(BIAS);
  localparam logic signed [RW-1:0] Rnd   = (SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] ActMax = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] ActMin = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    s1_valid_q;
  logic signed [TW-1:0]    t_q;
  logic                    s2_valid_q;
  logic        [OUT_W-1:0] act_q;
  logic                    sat_q;
  logic        [CNT_W-1:0] cnt_q;

  logic                    s2_take;
  logic                    s1_move;
  logic                    in_fire;
  logic                    out_fire;
  logic signed [TW-1:0]    t_d;
  logic signed [RW-1:0]    t_ext;
  logic signed [RW-1:0]    r;
  logic        [OUT_W-1:0] act_d;
  logic                    sat_d;

  // Handshake: S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  always_comb begin
    s2_take  = !s2_valid_q || out_ready;
    s1_move  = s1_valid_q && s2_take;
    in_ready = !s1_valid_q || s2_take;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  assign t_d = $signed({in_sum[IN_W-1], in_sum}) + BiasT;

  // Round-half-up: add half an LSB of the result, then floor via arithmetic shift.
  always_comb begin
    t_ext = {t_q[TW-1], t_q};
    r     = (t_ext + Rnd) >>> SHIFT;
    act_d = r[OUT_W-1:0];
    sat_d = 1'b0;
    if (RELU && r[RW-1]) begin
      act_d = '0;
    end else if (r > ActMax) begin
      act_d = ActMax[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (r < ActMin) begin
      act_d = ActMin[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      t_q        <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        t_q        <= t_d;
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      act_q      <= '0;
      sat_q      <= 1'b0;
    end else if (s2_take) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        act_q <= act_d;
        sat_q <= sat_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sat_clr) begin
      cnt_q <= '0;
    end else if (out_fire && sat_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_act   = act_q;
  assign out_sat   = sat_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_neuron_act_requant.sv
// Bench for neuron_act_requant. Two instances share one stimulus stream:
//   dut_a: SHIFT=8, BIAS=0,  RELU=1, CNT_W=16
//   dut_b: SHIFT=8, BIAS=64, RELU=0, CNT_W=2
// A negedge monitor keeps an expected-result queue per instance plus a sat_count model and
// checks every cycle; the main process runs directed scenarios with literal expectations.
module tb_neuron_act_requant;

  localparam int SHIFT  = 8;
  localparam int BIAS_A = 0;
  localparam int BIAS_B = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sat_clr = 1'b0;
  logic [31:0] in_sum = '0;

  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sat_a, out_sat_b;
  logic [15:0] out_act_a, out_act_b;
  logic [15:0] sat_count_a;
  logic [1:0]  sat_count_b;

  always #5 clk = ~clk;

  neuron_act_requant #(
    .IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .BIAS(BIAS_A), .RELU(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_act(out_act_a), .out_sat(out_sat_a),
    .sat_clr(sat_clr), .sat_count(sat_count_a)
  );

  neuron_act_requant #(
    .IN_W(32), .OUT_W(16), .SHIFT(SHIFT), .BIAS(BIAS_B), .RELU(1'b0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_act(out_act_b), .out_sat(out_sat_b),
    .sat_clr(sat_clr), .sat_count(sat_count_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: {sat, act} computed with wide integer arithmetic.
  function automatic logic [16:0] model(input logic [31:0] sum, input longint bias,
                                        input bit relu);
    longint t, r;
    logic [16:0] res;
    t = longint'($signed(sum)) + bias;
    r = (t + (longint'(1) << (SHIFT - 1))) >>> SHIFT;  // floor((t + half) / 2^SHIFT)
    if (relu && r < 0)       res = {1'b0, 16'h0000};
    else if (r > 32767)      res = {1'b1, 16'h7FFF};
    else if (r < -32768)     res = {1'b1, 16'h8000};
    else                     res = {1'b0, r[15:0]};
    return res;
  endfunction

  logic [16:0] qa[$];
  logic [16:0] qb[$];
  longint      cnt_a_m = 0;
  longint      cnt_b_m = 0;

  // Compare process: checks outputs now, then applies the effect of the coming edge.
  always @(negedge clk) begin : monitor
    logic [16:0] s;
    bit fa, fb;
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a_m = 0;
      cnt_b_m = 0;
    end else begin
      check("sat_count_a", sat_count_a, cnt_a_m);
      check("sat_count_b", sat_count_b, cnt_b_m);
      if (out_valid_a) begin
        if (qa.size() == 0) check("a_spurious_out", 1, 0);
        else begin
          check("a_act", out_act_a, qa[0][15:0]);
          check("a_sat", out_sat_a, qa[0][16]);
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) check("b_spurious_out", 1, 0);
        else begin
          check("b_act", out_act_b, qb[0][15:0]);
          check("b_sat", out_sat_b, qb[0][16]);
        end
      end
      fa = 1'b0;
      fb = 1'b0;
      if (out_valid_a && out_ready && qa.size() > 0) begin
        s = qa.pop_front();
        fa = s[16];
      end
      if (out_valid_b && out_ready && qb.size() > 0) begin
        s = qb.pop_front();
        fb = s[16];
      end
      if (sat_clr) cnt_a_m = 0;
      else if (fa && cnt_a_m < 65535) cnt_a_m++;
      if (sat_clr) cnt_b_m = 0;
      else if (fb && cnt_b_m < 3) cnt_b_m++;
      if (in_valid && in_ready_a) begin
        qa.push_back(model(in_sum, BIAS_A, 1'b1));
        qb.push_back(model(in_sum, BIAS_B, 1'b0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] sum);
    bit acc;
    in_valid = 1'b1;
    in_sum   = sum;
    acc      = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = in_ready_a;
      step();
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_out();
    for (int n = 0; n < 20 && !out_valid_a; n++) step();
    check("wait_out", out_valid_a, 1);
  endtask

  function automatic logic [31:0] rand_sum();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
      2:       v = 32'(32767 * 256) + 32'($urandom_range(0, 512)) - 32'd256;
      default: v = 32'(-32768 * 256) + 32'($urandom_range(0, 512)) - 32'd256;
    endcase
    return v;
  endfunction

  logic [15:0] got[$];
  int sent, cyc;
  bit acc;

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_act", out_act_a, 0);
    check("rst_out_sat", out_sat_b, 0);
    check("rst_sat_count", sat_count_a, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready_a, 1);

    // Pin the model with hand-computed values
    check("model_896", model(32'd896, 0, 1'b1), {1'b0, 16'd4});
    check("model_m1000_relu0", model(-32'sd1000, 0, 1'b0), {1'b0, 16'hFFFC});
    check("model_max", model(32'h7FFFFFFF, 0, 1'b1), {1'b1, 16'h7FFF});
    check("model_min_relu0", model(32'h80000000, 0, 1'b0), {1'b1, 16'h8000});

    // T1: 896 -> 4, two cycles after accept
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 32'd896;
    #1;
    check("t1_in_ready", in_ready_a, 1);
    step();
    in_valid = 1'b0;
    check("t1_lat1_valid", out_valid_a, 0);
    step();
    check("t1_lat2_valid", out_valid_a, 1);
    check("t1_act_a", out_act_a, 4);
    check("t1_act_b", out_act_b, 4);
    check("t1_sat_a", out_sat_a, 0);
    step();
    check("t1_consumed", out_valid_a, 0);

    // T2: -1000 -> 0 with ReLU, -4 without
    send(-32'sd1000);
    wait_out();
    check("t2_act_a", out_act_a, 0);
    check("t2_sat_a", out_sat_a, 0);
    check("t2_act_b", $signed(out_act_b), -4);
    check("t2_sat_b", out_sat_b, 0);
    step();

    // T3: saturation both ways
    send(32'h7FFFFFFF);
    wait_out();
    check("t3_act_a", out_act_a, 32767);
    check("t3_sat_a", out_sat_a, 1);
    check("t3_act_b", out_act_b, 32767);
    step();
    check("t3_cnt_a", sat_count_a, 1);
    check("t3_cnt_b", sat_count_b, 1);
    send(32'h80000000);
    wait_out();
    check("t3_min_act_a", out_act_a, 0);
    check("t3_min_sat_a", out_sat_a, 0);
    check("t3_min_act_b", $signed(out_act_b), -32768);
    check("t3_min_sat_b", out_sat_b, 1);
    step();
    check("t3_cnt_a2", sat_count_a, 1);
    check("t3_cnt_b2", sat_count_b, 2);

    // T4: stall capacity, then ordered drain
    out_ready = 1'b0;
    send(32'd2560);
    send(32'd5120);
    in_valid = 1'b1;
    in_sum   = 32'd7680;
    #1;
    check("t4_full_in_ready", in_ready_a, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_in_ready", in_ready_a, 0);
      check("t4_hold_valid", out_valid_a, 1);
      check("t4_hold_act", out_act_a, 10);
    end
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_comb", in_ready_a, 1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid_a) got.push_back(out_act_a);
      step();
      if (i == 0) in_valid = 1'b0;
    end
    check("t4_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t4_first", got[0], 10);
      check("t4_second", got[1], 20);
      check("t4_third", got[2], 30);
    end

    // T5: random valid/ready stress, checked by the monitor
    sent = 0;
    cyc  = 0;
    while (sent < 3000 && cyc < 40000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_sum   = rand_sum();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready_a;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t5_sent", sent, 3000);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && qa.size() > 0; n++) step();
    check("t5_drain_a", qa.size(), 0);
    check("t5_drain_b", qb.size(), 0);

    // T6: async reset with both stages full
    out_ready = 1'b0;
    send(32'd2560);
    send(32'd5120);
    step();
    check("t6_full_valid", out_valid_a, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid_a", out_valid_a, 0);
    check("t6_rst_valid_b", out_valid_b, 0);
    check("t6_rst_act", out_act_a, 0);
    check("t6_rst_cnt", sat_count_a, 0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_stale", out_valid_a, 0);
    end
    check("t6_in_ready", in_ready_a, 1);

    // sat_count saturation and clear priority
    for (int i = 0; i < 5; i++) send(32'h7FFFFFFF);
    repeat (4) step();
    check("t6_cnt_a5", sat_count_a, 5);
    check("t6_cnt_b_hold", sat_count_b, 3);
    send(32'h7FFFFFFF);
    wait_out();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("t6_clr_a", sat_count_a, 0);
    check("t6_clr_b", sat_count_b, 0);
    repeat (3) step();
    check("t6_end_a", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
